uart_xcvr: RTL and testbench

//  Parametrised full-duplex UART transceiver: valid/ready byte interfaces on the

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_baud_gen.sv | 31 +++
 rtl/uart_xcvr.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_xcvr.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, TX/RX state encodings and the parity helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // Parity bit to append to data; bits above the payload width must be zero.
    function automatic logic parity_calc(input logic [8:0] data, input int mode);
        logic result;
        result = 1'b0;
        case (mode)
            PARITY_ODD:  result = ~(^data);
            PARITY_EVEN: result = ^data;
            default:     result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: free-running divisor counter, one-cycle tick on wrap.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] lim;
    logic [DIV_W-1:0] div_eff;

    assign div_eff = (div == '0) ? DIV_W'(1) : div;
    assign tick    = (cnt == lim - DIV_W'(1));

    // The limit is only re-sampled on wrap, so a divisor change never truncates a period.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            lim <= div_eff;
        end else if (tick) begin
            cnt <= '0;
            lim <= div_eff;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex UART transceiver with valid/ready byte ports and internal loopback.
// Handshakes: a transfer happens on a cycle where valid & ready are both high.
module uart_xcvr
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int OSR       = 16,
    parameter int DIV_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DIV_W-1:0]     baud_div_i,
    input  logic                 loopback_i,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 tx_busy_o,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 rx_parity_err_o,
    output logic                 rx_frame_err_o,
    output logic                 rx_overrun_o,
    input  logic                 serial_in_i,
    output logic                 serial_out_o
);

    localparam int CNT_W = $clog2(OSR * 2) + 1;
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OSR - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OSR / 2 - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * OSR - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic tick;

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk  (clk_i),
        .rst  (rst_i),
        .div  (baud_div_i),
        .tick (tick)
    );

    tx_state_e            tx_state;
    logic [CNT_W-1:0]     tx_cnt;
    logic [IDX_W-1:0]     tx_idx;
    logic [DATA_BITS-1:0] tx_shr;
    logic                 tx_par;
    logic                 tx_line;
    logic                 tx_rdy;
    logic                 out_q;
    logic                 tx_bit_end;

    assign tx_bit_end   = tick && (tx_cnt == BIT_LAST);
    assign tx_ready_o   = tx_rdy;
    assign tx_busy_o    = (tx_state != TX_IDLE);
    assign serial_out_o = out_q;

    // tx_line is the internal TX line; out_q mirrors it (forced high in loopback)
    // and is updated alongside tx_line so the pin carries no extra cycle of delay.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shr   <= '0;
            tx_par   <= 1'b0;
            tx_line  <= 1'b1;
            tx_rdy   <= 1'b1;
            out_q    <= 1'b1;
        end else begin
            out_q <= loopback_i | tx_line;
            if (tick) tx_cnt <= tx_cnt + CNT_W'(1);
            case (tx_state)
                TX_IDLE: begin
                    tx_cnt <= '0;
                    if (tx_valid_i && tx_rdy) begin
                        tx_shr   <= tx_data_i;
                        tx_par   <= parity_calc(9'(tx_data_i), PARITY);
                        tx_rdy   <= 1'b0;
                        tx_line  <= 1'b0;
                        out_q    <= loopback_i;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        tx_line  <= tx_shr[0];
                        out_q    <= loopback_i | tx_shr[0];
                        tx_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        if (tx_idx == IDX_LAST) begin
                            if (PARITY != PARITY_NONE) begin
                                tx_line  <= tx_par;
                                out_q    <= loopback_i | tx_par;
                                tx_state <= TX_PARITY;
                            end else begin
                                tx_line  <= 1'b1;
                                out_q    <= 1'b1;
                                tx_state <= TX_STOP;
                            end
                        end else begin
                            tx_idx  <= tx_idx + IDX_W'(1);
                            tx_shr  <= tx_shr >> 1;
                            tx_line <= tx_shr[1];
                            out_q   <= loopback_i | tx_shr[1];
                        end
                    end
                end
                TX_PARITY: begin
                    if (tx_bit_end) begin
                        tx_cnt   <= '0;
                        tx_line  <= 1'b1;
                        out_q    <= 1'b1;
                        tx_state <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (tick && (tx_cnt == STOP_LAST)) begin
                        tx_cnt   <= '0;
                        tx_rdy   <= 1'b1;
                        tx_state <= TX_IDLE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    rx_state_e            rx_state;
    logic [1:0]           rx_sync;
    logic                 rx_in;
    logic [CNT_W-1:0]     rx_cnt;
    logic [IDX_W-1:0]     rx_idx;
    logic [DATA_BITS-1:0] rx_shr;
    logic                 rx_par;
    logic                 rx_bit_end;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 rx_perr_q;
    logic                 rx_ferr_q;
    logic                 rx_ovr_q;

    assign rx_in           = loopback_i ? tx_line : rx_sync[1];
    assign rx_bit_end      = tick && (rx_cnt == BIT_LAST);
    assign rx_data_o       = rx_data_q;
    assign rx_valid_o      = rx_valid_q;
    assign rx_parity_err_o = rx_perr_q;
    assign rx_frame_err_o  = rx_ferr_q;
    assign rx_overrun_o    = rx_ovr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_state   <= RX_IDLE;
            rx_sync    <= 2'b11;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_shr     <= '0;
            rx_par     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], serial_in_i};
            if (tick) rx_cnt <= rx_cnt + CNT_W'(1);
            if (rx_valid_q && rx_ready_i) begin
                rx_valid_q <= 1'b0;
                rx_ovr_q   <= 1'b0;
            end
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (tick && !rx_in) rx_state <= RX_START;
                end
                RX_START: begin
                    // Half a bit after the falling edge: still low means a real start bit.
                    if (tick && (rx_cnt == HALF_LAST)) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_state <= rx_in ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_bit_end) begin
                        rx_cnt <= '0;
                        rx_shr <= {rx_in, rx_shr[DATA_BITS-1:1]};
                        if (rx_idx == IDX_LAST) begin
                            rx_state <= (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_idx <= rx_idx + IDX_W'(1);
                        end
                    end
                end
                RX_PARITY: begin
                    if (rx_bit_end) begin
                        rx_cnt   <= '0;
                        rx_par   <= rx_in;
                        rx_state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    // A load overrides a same-cycle accept; overrun only if nobody took the old byte.
                    if (rx_bit_end) begin
                        rx_cnt     <= '0;
                        rx_data_q  <= rx_shr;
                        rx_perr_q  <= (PARITY != PARITY_NONE) &&
                                      (parity_calc(9'(rx_shr), PARITY) != rx_par);
                        rx_ferr_q  <= ~rx_in;
                        rx_valid_q <= 1'b1;
                        rx_ovr_q   <= rx_valid_q && !rx_ready_i;
                        rx_state   <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_xcvr.sv
// Directed bench for uart_xcvr: an 8N1 instance and an 8E1 instance, 64 clk per bit.
module tb_uart_xcvr;
    import uart_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] div;

    logic       lb_a, txv_a, txr_a, busy_a, rxv_a, rxr_a, pe_a, fe_a, ov_a, si_a, so_a;
    logic [7:0] txd_a, rxd_a;
    logic       lb_b, txv_b, txr_b, busy_b, rxv_b, rxr_b, pe_b, fe_b, ov_b, si_b, so_b;
    logic [7:0] txd_b, rxd_b;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    uart_xcvr #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OSR(16), .DIV_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .baud_div_i(div), .loopback_i(lb_a),
        .tx_data_i(txd_a), .tx_valid_i(txv_a), .tx_ready_o(txr_a), .tx_busy_o(busy_a),
        .rx_data_o(rxd_a), .rx_valid_o(rxv_a), .rx_ready_i(rxr_a),
        .rx_parity_err_o(pe_a), .rx_frame_err_o(fe_a), .rx_overrun_o(ov_a),
        .serial_in_i(si_a), .serial_out_o(so_a)
    );

    uart_xcvr #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OSR(16), .DIV_W(16)) dut_p (
        .clk_i(clk), .rst_i(rst), .baud_div_i(div), .loopback_i(lb_b),
        .tx_data_i(txd_b), .tx_valid_i(txv_b), .tx_ready_o(txr_b), .tx_busy_o(busy_b),
        .rx_data_o(rxd_b), .rx_valid_o(rxv_b), .rx_ready_i(rxr_b),
        .rx_parity_err_o(pe_b), .rx_frame_err_o(fe_b), .rx_overrun_o(ov_b),
        .serial_in_i(si_b), .serial_out_o(so_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input bit sel, input logic [7:0] d);
        int n;
        n = 0;
        while (((sel ? txr_b : txr_a) == 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_wait", sel ? txr_b : txr_a, 1);
        if (sel) begin txd_b = d; txv_b = 1'b1; end
        else     begin txd_a = d; txv_a = 1'b1; end
        @(negedge clk);
        txv_a = 1'b0;
        txv_b = 1'b0;
    endtask

    task automatic wait_rx(input bit sel, input string tag);
        int n;
        n = 0;
        while (((sel ? rxv_b : rxv_a) == 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, sel ? rxv_b : rxv_a, 1);
    endtask

    task automatic accept(input bit sel);
        if (sel) rxr_b = 1'b1; else rxr_a = 1'b1;
        @(negedge clk);
        rxr_a = 1'b0;
        rxr_b = 1'b0;
    endtask

    task automatic drive_frame(input bit sel, input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (sel) si_b = bits[i]; else si_a = bits[i];
            repeat (64) @(negedge clk);
        end
    endtask

    task automatic check_rx_a(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_data"}, rxd_a, e);
            check({tag, "_perr"}, pe_a, 0);
            check({tag, "_ferr"}, fe_a, 0);
            check({tag, "_ovr"}, ov_a, 0);
        end
    endtask

    initial begin
        int len;
        bit seen;
        rst = 1'b1; div = 16'd4;
        lb_a = 1'b1; txv_a = 1'b0; txd_a = '0; rxr_a = 1'b0; si_a = 1'b1;
        lb_b = 1'b0; txv_b = 1'b0; txd_b = '0; rxr_b = 1'b0; si_b = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_serial_out", so_a, 1);
        check("rst_tx_ready", txr_a, 1);
        check("rst_tx_busy", busy_a, 0);
        check("rst_rx_valid", rxv_a, 0);
        check("rst_rx_data", rxd_a, 0);
        check("rst_errs", {pe_a, fe_a, ov_a}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: 8N1 loopback of 0xA5, tx_ready low for 10 bits = 640 clk (tick phase +-4)
        exp_q.push_back(8'hA5);
        send(0, 8'hA5);
        check("t1_busy", busy_a, 1);
        check("t1_loop_line_high", so_a, 1);
        len = 0;
        while (!txr_a && len < 3000) begin
            len++;
            @(negedge clk);
        end
        check("t1_ready_low_len_ok", (len >= 636 && len <= 641), 1);
        wait_rx(0, "t1_rx_valid");
        check_rx_a("t1");
        accept(0);
        check("t1_rx_valid_cleared", rxv_a, 0);

        // 2: even parity, 0x07 has three ones -> parity bit 1
        send(1, 8'h07);
        repeat (32) @(negedge clk);
        check("t2_start_bit", so_b, 0);
        repeat (64) @(negedge clk);
        check("t2_d0", so_b, 1);
        repeat (64 * 8) @(negedge clk);
        check("t2_parity_bit", so_b, 1);
        repeat (64) @(negedge clk);
        check("t2_stop_bit", so_b, 1);
        repeat (100) @(negedge clk);
        drive_frame(1, {1'b1, 1'b0, 8'h07, 1'b0}, 11);
        wait_rx(1, "t2_bad_rx_valid");
        check("t2_bad_data", rxd_b, 8'h07);
        check("t2_bad_perr", pe_b, 1);
        check("t2_bad_ferr", fe_b, 0);
        accept(1);
        drive_frame(1, {1'b1, 1'b1, 8'h07, 1'b0}, 11);
        wait_rx(1, "t2_good_rx_valid");
        check("t2_good_data", rxd_b, 8'h07);
        check("t2_good_perr", pe_b, 0);
        accept(1);

        // 3: 20-clk glitch on the line
        lb_a = 1'b0;
        repeat (10) @(negedge clk);
        si_a = 1'b0;
        repeat (20) @(negedge clk);
        si_a = 1'b1;
        repeat (8) @(negedge clk);
        check("t3_in_start", 32'(dut.rx_state), 32'(RX_START));
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rxv_a) seen = 1'b1;
        end
        check("t3_no_rx_valid", seen, 0);
        check("t3_rx_idle", 32'(dut.rx_state), 32'(RX_IDLE));

        // 4: 0x3C with a low stop bit
        drive_frame(0, {8'h3C, 1'b0}, 9);
        si_a = 1'b0;
        repeat (48) @(negedge clk);
        si_a = 1'b1;
        wait_rx(0, "t4_rx_valid");
        check("t4_data", rxd_a, 8'h3C);
        check("t4_ferr", fe_a, 1);
        check("t4_perr", pe_a, 0);
        accept(0);
        repeat (200) @(negedge clk);
        check("t4_no_spurious", rxv_a, 0);

        // 5: two frames without accepting -> overrun
        lb_a = 1'b1;
        repeat (10) @(negedge clk);
        send(0, 8'h11);
        send(0, 8'h22);
        len = 0;
        while (!txr_a && len < 3000) begin
            len++;
            @(negedge clk);
        end
        check("t5_tx_done", txr_a, 1);
        check("t5_rx_valid", rxv_a, 1);
        check("t5_data", rxd_a, 8'h22);
        check("t5_overrun", ov_a, 1);
        accept(0);
        check("t5_valid_cleared", rxv_a, 0);
        check("t5_overrun_cleared", ov_a, 0);

        // 6: reset in the middle of a frame (0x5A, d0=0 on the line)
        lb_a = 1'b0;
        repeat (10) @(negedge clk);
        send(0, 8'h5A);
        repeat (100) @(negedge clk);
        check("t6_line_low_mid_d0", so_a, 0);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_line_high", so_a, 1);
        check("t6_rst_ready", txr_a, 1);
        check("t6_rst_busy", busy_a, 0);
        rst = 1'b0;
        lb_a = 1'b1;
        repeat (10) @(negedge clk);
        exp_q.push_back(8'h96);
        send(0, 8'h96);
        wait_rx(0, "t6_rx_valid");
        check_rx_a("t6");
        accept(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
